lc3_memaccess: RTL

Data-memory access stage of the LC3 pipeline; the producer end of the `memout` value the writeback stage selects when `W_Control` = 1. It accepts a load/store request from the execute/controller side, sequences one or two data-memory transactions (direct or indirect), and returns the loaded word with a done pulse. Stores complete without altering `memout`.

---
 rtl/lc3_pkg.sv | 35 +++
 rtl/lc3_memaccess_if.sv | 40 ++++
 rtl/lc3_memaccess.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC3 pipeline types and helpers.
// Holds the memory-operation encoding, the memory-access FSM state type and
// the {N,Z,P} condition-code helper shared with writeback.
package lc3_pkg;

    // Encoding of the mem_op request field
    typedef enum logic [1:0] {
        READ      = 2'd0,
        WRITE     = 2'd1,
        IND_READ  = 2'd2,
        IND_WRITE = 2'd3
    } mem_op_t;

    // States of the data-memory access sequencer
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC1  = 3'd1,
        DATA1 = 3'd2,
        ACC2  = 3'd3,
        DATA2 = 3'd4,
        DONE  = 3'd5
    } memacc_state_t;

    // {N,Z,P} code from the sign bit and a zero flag of a word.
    // Taking the two flags keeps the helper independent of the data width.
    function automatic logic [2:0] nzp(input logic neg, input logic zero);
        if (neg)
            return 3'b100;
        else if (zero)
            return 3'b010;
        else
            return 3'b001;
    endfunction

endpackage

// File: rtl/lc3_memaccess_if.sv
// lc3_memaccess_if: request/response and data-memory bus of the LC3
// memory-access stage. The psr signal exists only when MEMACCESS_PSR_EN
// is defined.
interface lc3_memaccess_if #(parameter int DW = 16);

    logic          mem_start;
    logic [1:0]    mem_op;
    logic [DW-1:0] M_Addr;
    logic [DW-1:0] M_Data;
    logic [DW-1:0] dmem_dout;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_din;
    logic          dmem_rd;
    logic          dmem_wr;
    logic [DW-1:0] memout;
    logic          mem_busy;
    logic          mem_done;
`ifdef MEMACCESS_PSR_EN
    logic [2:0]    psr;
`endif

    // The memory-access stage itself
    modport slave (
        input  mem_start, mem_op, M_Addr, M_Data, dmem_dout,
        output dmem_addr, dmem_din, dmem_rd, dmem_wr, memout, mem_busy, mem_done
`ifdef MEMACCESS_PSR_EN
        , output psr
`endif
    );

    // The controller / memory side driving requests and read data
    modport master (
        output mem_start, mem_op, M_Addr, M_Data, dmem_dout,
        input  dmem_addr, dmem_din, dmem_rd, dmem_wr, memout, mem_busy, mem_done
`ifdef MEMACCESS_PSR_EN
        , input psr
`endif
    );

endinterface

// File: rtl/lc3_memaccess.sv
// lc3_memaccess: data-memory access stage of the LC3 pipeline.
// Sequences one (direct) or two (indirect) memory transactions per request
// and returns the loaded word in memout with a one-cycle mem_done pulse.
// Optional feature: MEMACCESS_PSR_EN adds the psr {N,Z,P} output of the
// last loaded word.
module lc3_memaccess
    import lc3_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic           clock,
    input  logic           reset,
    lc3_memaccess_if.slave bus
);

    memacc_state_t state;
    memacc_state_t state_next;

    mem_op_t       op_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] ptr_q;
    logic [DW-1:0] memout_q;
`ifdef MEMACCESS_PSR_EN
    logic [2:0]    psr_q;
`endif

    // State register; reset abandons any operation in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state sequencing: one access for direct ops, pointer fetch first for indirect ops
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.mem_start) state_next = ACC1;
            ACC1:  state_next = (op_q == WRITE) ? DONE : DATA1;
            DATA1: state_next = (op_q == READ) ? DONE : ACC2;
            ACC2:  state_next = (op_q == IND_WRITE) ? DONE : DATA2;
            DATA2: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, pointer capture and load-result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= READ;
            addr_q   <= '0;
            data_q   <= '0;
            ptr_q    <= '0;
            memout_q <= '0;
`ifdef MEMACCESS_PSR_EN
            psr_q    <= 3'b000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_start) begin
                        op_q   <= mem_op_t'(bus.mem_op);
                        addr_q <= bus.M_Addr;
                        data_q <= bus.M_Data;
                    end
                end
                DATA1: begin
                    if (op_q == READ) begin
                        memout_q <= bus.dmem_dout;
`ifdef MEMACCESS_PSR_EN
                        psr_q    <= nzp(bus.dmem_dout[DW-1], bus.dmem_dout == '0);
`endif
                    end else begin
                        ptr_q <= bus.dmem_dout;
                    end
                end
                DATA2: begin
                    memout_q <= bus.dmem_dout;
`ifdef MEMACCESS_PSR_EN
                    psr_q    <= nzp(bus.dmem_dout[DW-1], bus.dmem_dout == '0);
`endif
                end
                default: ;
            endcase
        end
    end

    // Moore memory-bus strobes and status decoded from state and latched registers
    always_comb begin
        bus.dmem_addr = '0;
        bus.dmem_din  = '0;
        bus.dmem_rd   = 1'b0;
        bus.dmem_wr   = 1'b0;
        bus.mem_done  = 1'b0;
        case (state)
            ACC1: begin
                bus.dmem_addr = addr_q;
                if (op_q == WRITE) begin
                    bus.dmem_wr  = 1'b1;
                    bus.dmem_din = data_q;
                end else begin
                    bus.dmem_rd = 1'b1;
                end
            end
            ACC2: begin
                bus.dmem_addr = ptr_q;
                if (op_q == IND_WRITE) begin
                    bus.dmem_wr  = 1'b1;
                    bus.dmem_din = data_q;
                end else begin
                    bus.dmem_rd = 1'b1;
                end
            end
            DONE: bus.mem_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_busy = (state != IDLE);
    assign bus.memout   = memout_q;
`ifdef MEMACCESS_PSR_EN
    assign bus.psr      = psr_q;
`endif

endmodule
